// File: rtl/sha256_host_ctrl.sv
`timescale 1ns/1ps
// Host controller and memory responder for simplified_sha256: load message, kick hasher, unload 8 digest words.
// Latency: start on the edge after the last accept; registered reads have 1 cycle latency; unload is 2 cycles per word.
// Backpressure: in_ready low outside IDLE/LOAD, out_valid/out_data held until out_ready. Watchdog: SHA_HOST_TIMEOUT_EN.
module sha256_host_ctrl #(
  parameter int          NUM_OF_WORDS = 20,
  parameter int          DEPTH        = 256,
  parameter logic [15:0] MSG_BASE     = 16'h0000,
  parameter logic [15:0] OUT_BASE     = 16'h0080,
  parameter int          TIMEOUT      = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        error,
  output logic        start,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic        done,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(NUM_OF_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_WAIT_BUSY, S_WAIT_DONE, S_UNLOAD_RD, S_UNLOAD_OUT
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    k;
  logic [31:0]   mem [DEPTH];
  logic          accept, last_word, host_we, hasher_we, timeout_hit;
  logic [15:0]   host_addr, unload_addr;
  logic          unused_addr_bits;

  assign message_addr = MSG_BASE;
  assign output_addr  = OUT_BASE;

  assign accept      = in_valid && in_ready;
  assign last_word   = accept && (cnt == CW'(NUM_OF_WORDS - 1));
  assign host_addr   = MSG_BASE + 16'(cnt);
  assign unload_addr = OUT_BASE + {13'd0, k};
  assign host_we     = accept;
  // The host owns the write port while loading; hasher writes then are dropped.
  assign hasher_we   = mem_we && (state != S_IDLE) && (state != S_LOAD);
  assign unused_addr_bits = ^{mem_addr[15:AW], host_addr[15:AW], unload_addr[15:AW]};

`ifdef SHA_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  assign timeout_hit = ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE)) &&
                       (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt  <= '0;
      error <= 1'b0;
    end else begin
      if (state == S_KICK)
        tcnt <= '0;
      else if ((state == S_WAIT_BUSY) || (state == S_WAIT_DONE))
        tcnt <= tcnt + TW'(1);
      if (accept && (state == S_IDLE))
        error <= 1'b0;
      else if (timeout_hit)
        error <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:       if (accept) state_nxt = last_word ? S_KICK : S_LOAD;
      S_LOAD:       if (last_word) state_nxt = S_KICK;
      S_KICK:       state_nxt = S_WAIT_BUSY;
      // done idles high, so its low phase must be seen before waiting for completion
      S_WAIT_BUSY:  if (timeout_hit) state_nxt = S_IDLE;
                    else if (!done) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE:  if (timeout_hit) state_nxt = S_IDLE;
                    else if (done) state_nxt = S_UNLOAD_RD;
      S_UNLOAD_RD:  state_nxt = S_UNLOAD_OUT;
      S_UNLOAD_OUT: if (out_ready) state_nxt = (k == 3'd7) ? S_IDLE : S_UNLOAD_RD;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    start     = 1'b0;
    busy      = 1'b1;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE:       begin in_ready = 1'b1; busy = 1'b0; end
      S_LOAD:       in_ready  = 1'b1;
      S_KICK:       start     = 1'b1;
      S_UNLOAD_OUT: out_valid = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      k        <= 3'd0;
      out_data <= 32'd0;
    end else begin
      if (timeout_hit)
        cnt <= '0;
      else if (accept)
        cnt <= last_word ? '0 : cnt + CW'(1);
      if ((state == S_WAIT_DONE) && done)
        k <= 3'd0;
      else if ((state == S_UNLOAD_OUT) && out_ready)
        k <= k + 3'd1;
      // Unload has its own read path so the hasher's read data is untouched.
      if (state == S_UNLOAD_RD)
        out_data <= mem[unload_addr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_read_data <= 32'd0;
    else       mem_read_data <= mem[mem_addr[AW-1:0]];
  end

  // Contents are deliberately not reset; read-during-write yields the old word.
  always_ff @(posedge clk) begin
    if (host_we)
      mem[host_addr[AW-1:0]] <= in_data;
    else if (hasher_we)
      mem[mem_addr[AW-1:0]] <= mem_write_data;
  end

endmodule

// File: tb/tb_sha256_host_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for sha256_host_ctrl with a behavioural hasher model and a SHA-256 reference digest.
module tb_sha256_host_ctrl;

`ifdef SHA_HOST_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = 4096;
`endif
  localparam logic [15:0] MSGB = 16'h0000;
  localparam logic [15:0] OUTB = 16'h0080;

  logic        clk = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1, done = 1'b1, mem_we = 1'b0;
  logic [31:0] in_data = 32'd0, mem_write_data = 32'd0;
  logic [15:0] mem_addr = 16'd0;
  logic        in_ready, out_valid, busy, error, start;
  logic [31:0] out_data, mem_read_data;
  logic [15:0] message_addr, output_addr;

  int tests = 0;
  int fails = 0;
  logic [31:0] msg [20];
  logic [31:0] hw_msg [20];
  logic [31:0] exp_h [8];

  logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  sha256_host_ctrl #(.NUM_OF_WORDS(20), .DEPTH(256), .MSG_BASE(MSGB), .OUT_BASE(OUTB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .error(error), .start(start),
    .message_addr(message_addr), .output_addr(output_addr),
    .done(done), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data));

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Standard SHA-256 of a 640-bit message (two padded blocks).
  function automatic logic [255:0] sha256_640(input logic [639:0] m);
    logic [31:0] blk [32];
    logic [31:0] w [64];
    logic [31:0] hh [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 20; i++) blk[i] = m[639 - 32*i -: 32];
    blk[20] = 32'h8000_0000;
    for (int i = 21; i < 31; i++) blk[i] = 32'd0;
    blk[31] = 32'd640;
    hh = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int bn = 0; bn < 2; bn++) begin
      for (int t = 0; t < 16; t++) w[t] = blk[16*bn + t];
      for (int t = 16; t < 64; t++)
        w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
               (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      a = hh[0]; b = hh[1]; c = hh[2]; d = hh[3]; e = hh[4]; f = hh[5]; g = hh[6]; h = hh[7];
      for (int t = 0; t < 64; t++) begin
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
      hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += h;
    end
    return {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Streams msg[] in; checks a single start pulse right after the last accept.
  task automatic load_msg(input bit gap);
    int acc = 0, cyc = 0, starts = 0;
    bit rdy, v;
    while (acc < 20 && cyc < 200) begin
      rdy = in_ready;
      v = gap ? ((cyc % 3) != 2) : 1'b1;
      in_valid = v;
      in_data  = msg[acc];
      step();
      cyc++;
      if (start) starts++;
      if (v && rdy) begin
        acc++;
        if (acc == 20) begin
          tests++;
          if (start !== 1'b1) begin fails++; $display("FAIL start_after_last: start=%b required 1", start); end
        end
      end
    end
    in_valid = 1'b0;
    tests++;
    if (acc != 20) begin fails++; $display("FAIL load_accepts: got %0d required 20", acc); end
    step();
    tests++;
    if (start !== 1'b0 || starts != 1) begin
      fails++; $display("FAIL start_pulse: start=%b pulses=%0d required 0 and 1", start, starts);
    end
  endtask

  task automatic hasher_read_check();
    for (int i = 0; i < 20; i++) begin
      mem_addr = MSGB + 16'(i);
      step();
      hw_msg[i] = mem_read_data;
      tests++;
      if (mem_read_data !== msg[i]) begin
        fails++; $display("FAIL resp_read[%0d]: got %h required %h", i, mem_read_data, msg[i]);
      end
    end
  endtask

  task automatic hasher_write(input logic [15:0] a, input logic [31:0] d);
    mem_we = 1'b1; mem_addr = a; mem_write_data = d;
    step();
    mem_we = 1'b0;
  endtask

  // Collects 8 unload words against exp_h[]; bp>=0 holds out_ready low 10 cycles on that word.
  task automatic collect_out(input int bp);
    int got = 0, cyc = 0, hold = 0;
    bit r, v;
    logic [31:0] d;
    mem_addr = MSGB + 16'd3;
    while (got < 8 && cyc < 400) begin
      if (got == bp && hold < 10) r = 1'b0;
      else r = ($urandom_range(3) != 0);
      out_ready = r;
      v = out_valid;
      d = out_data;
      if (v && !r && got == bp) hold++;
      step();
      cyc++;
      if (v && r) begin
        tests++;
        if (d !== exp_h[got]) begin fails++; $display("FAIL out_word[%0d]: got %h required %h", got, d, exp_h[got]); end
        got++;
        if (got == 8) begin
          tests++;
          if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_unload: got %b required 0", busy); end
        end
      end else if (v) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== d) begin
          fails++; $display("FAIL out_stable: valid=%b data=%h required 1 %h", out_valid, out_data, d);
        end
      end
    end
    out_ready = 1'b1;
    tests++;
    if (got != 8) begin fails++; $display("FAIL unload_count: got %0d required 8", got); end
    tests++;
    if (mem_read_data !== msg[3]) begin
      fails++; $display("FAIL rd_path_undisturbed: got %h required %h", mem_read_data, msg[3]);
    end
    if (bp >= 0) begin
      tests++;
      if (hold != 10) begin fails++; $display("FAIL backpressure_hold: got %0d required 10", hold); end
    end
  endtask

  task automatic run_job(input int bp, input bit gap);
    logic [639:0] p;
    logic [255:0] dg;
    for (int i = 0; i < 20; i++) msg[i] = $urandom;
    load_msg(gap);
    done = 1'b0;
    step();
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_in_wait: got %b required 1", busy); end
    hasher_read_check();
    for (int i = 0; i < 20; i++) p[639 - 32*i -: 32] = hw_msg[i];
    dg = sha256_640(p);
    for (int i = 0; i < 8; i++) hasher_write(OUTB + 16'(i), dg[255 - 32*i -: 32]);
    for (int i = 0; i < 20; i++) p[639 - 32*i -: 32] = msg[i];
    dg = sha256_640(p);
    for (int i = 0; i < 8; i++) exp_h[i] = dg[255 - 32*i -: 32];
    done = 1'b1;
    collect_out(bp);
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (busy !== 0 || in_ready !== 1 || out_valid !== 0 || start !== 0 || error !== 0 ||
        out_data !== 0 || mem_read_data !== 0) begin
      fails++; $display("FAIL reset_state: busy=%b rdy=%b ov=%b st=%b err=%b od=%h rd=%h", busy, in_ready,
                        out_valid, start, error, out_data, mem_read_data);
    end
    tests++;
    if (message_addr !== MSGB || output_addr !== OUTB) begin
      fails++; $display("FAIL base_addrs: got %h %h required %h %h", message_addr, output_addr, MSGB, OUTB);
    end
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = $urandom;
      step();
    end
    in_valid = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_mid_load: got %b required 1", busy); end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (busy !== 0 || in_ready !== 1 || out_valid !== 0 || start !== 0) begin
      fails++; $display("FAIL reset_mid_load: busy=%b rdy=%b ov=%b st=%b required 0 1 0 0", busy, in_ready, out_valid, start);
    end
    step();
    reset = 1'b0;
    run_job(-1, 1'b0);
  endtask

  task automatic test_load_kick();
    for (int i = 0; i < 20; i++) msg[i] = 32'(i);
    load_msg(1'b1);
    done = 1'b0;
    step();
  endtask

  task automatic test_responder();
    hasher_read_check();
    hasher_write(OUTB, 32'h0BAD_0080);
    hasher_write(OUTB, 32'hA5A5_0000);
    tests++;
    if (mem_read_data !== 32'h0BAD_0080) begin
      fails++; $display("FAIL rdw_old: got %h required 0bad0080", mem_read_data);
    end
    step();
    tests++;
    if (mem_read_data !== 32'hA5A5_0000) begin
      fails++; $display("FAIL rdw_new: got %h required a5a50000", mem_read_data);
    end
    for (int i = 1; i < 8; i++) hasher_write(OUTB + 16'(i), 32'hA5A5_0000 + 32'(i));
    for (int i = 0; i < 8; i++) exp_h[i] = 32'hA5A5_0000 + 32'(i);
    for (int i = 1; i < 8; i++) begin
      mem_addr = OUTB + 16'(i);
      step();
      tests++;
      if (mem_read_data !== exp_h[i]) begin
        fails++; $display("FAIL resp_wr[%0d]: got %h required %h", i, mem_read_data, exp_h[i]);
      end
    end
    done = 1'b1;
    collect_out(-1);
  endtask

  task automatic test_full_job();
    run_job(-1, 1'b0);
    run_job(-1, 1'b1);
  endtask

  task automatic test_backpressure();
    run_job(3, 1'b0);
  endtask

`ifdef SHA_HOST_TIMEOUT_EN
  task automatic test_timeout();
    for (int i = 0; i < 20; i++) msg[i] = $urandom;
    load_msg(1'b0);
    for (int c = 0; c < 62; c++) step();
    tests++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL timeout_early: err=%b busy=%b required 0 1", error, busy);
    end
    step();
    tests++;
    if (error !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL timeout_hit: err=%b busy=%b rdy=%b required 1 0 1", error, busy, in_ready);
    end
    in_valid = 1'b1; in_data = $urandom;
    step();
    in_valid = 1'b0;
    tests++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL timeout_clear: err=%b busy=%b required 0 1", error, busy);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load_kick();
    test_responder();
    test_full_job();
    test_backpressure();
`ifdef SHA_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
